// File: rtl/lcd_reader_if.sv
// Request/response and LCD bus signals for the HD44780 read-side controller.
// The master side is the requester plus the LCD data bus; the slave side is lcd_reader.
interface lcd_reader_if;
  logic       req;
  logic       req_rs;
  logic       busy_wait;
  logic       ready;
  logic       done;
  logic       timeout;
  logic [7:0] rd_data;
  logic       busy_flag;
  logic [6:0] addr_cnt;
  logic       lcd_rw;
  logic       lcd_rs;
  logic       lcd_en;
  logic [7:0] lcd_data_in;

  modport master (
    output req, req_rs, busy_wait, lcd_data_in,
    input  ready, done, timeout, rd_data, busy_flag, addr_cnt, lcd_rw, lcd_rs, lcd_en
  );

  modport slave (
    input  req, req_rs, busy_wait, lcd_data_in,
    output ready, done, timeout, rd_data, busy_flag, addr_cnt, lcd_rw, lcd_rs, lcd_en
  );
endinterface

// File: rtl/lcd_reader.sv
// Timed HD44780 read cycles: returns the busy-flag/address byte or a data byte,
// optionally polling the busy flag until it clears or MAX_POLLS reads are spent.
module lcd_reader #(
  parameter int SETUP_CYC   = 2,
  parameter int EN_HIGH_CYC = 25,
  parameter int HOLD_CYC    = 2,
  parameter int MAX_POLLS   = 1000
) (
  input logic        clk,
  input logic        reset,
  lcd_reader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, EN_HIGH, HOLD} state_t;

  localparam int MAX_CYC = (EN_HIGH_CYC > SETUP_CYC) ?
                           ((EN_HIGH_CYC > HOLD_CYC) ? EN_HIGH_CYC : HOLD_CYC) :
                           ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC);
  localparam int CNT_W  = $clog2(MAX_CYC + 1);
  localparam int POLL_W = $clog2(MAX_POLLS + 1);

  localparam logic [CNT_W-1:0]  SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0]  EN_LD    = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0]  HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(MAX_POLLS);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [POLL_W-1:0]  poll_q, poll_d;
  logic               rs_q, rs_d;
  logic               bw_q, bw_d;
  logic               en_q, en_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               bf_q, bf_d;
  logic [6:0]         ac_q, ac_d;
  logic               last_cyc;
  logic               poll_again;

  assign last_cyc = (cnt_q == '0);
  // bf_q already holds this read's capture when RS=0, so it decides the re-poll.
  assign poll_again = !rs_q && bw_q && bf_q && (poll_q < POLL_MAX);

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    poll_d    = poll_q;
    rs_d      = rs_q;
    bw_d      = bw_q;
    en_d      = en_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    rd_data_d = rd_data_q;
    bf_d      = bf_q;
    ac_d      = ac_q;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.req) begin
          rs_d      = bus.req_rs;
          bw_d      = bus.busy_wait;
          poll_d    = '0;
          timeout_d = 1'b0;
          ready_d   = 1'b0;
          cnt_d     = SETUP_LD;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (last_cyc) begin
          en_d    = 1'b1;
          cnt_d   = EN_LD;
          state_d = EN_HIGH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      EN_HIGH: begin
        if (last_cyc) begin
          // Capture on the same edge that drops EN, while the LCD still drives the bus.
          rd_data_d = bus.lcd_data_in;
          if (!rs_q) begin
            bf_d   = bus.lcd_data_in[7];
            ac_d   = bus.lcd_data_in[6:0];
            poll_d = poll_q + POLL_W'(1);
          end
          en_d    = 1'b0;
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (last_cyc) begin
          if (poll_again) begin
            cnt_d   = SETUP_LD;
            state_d = SETUP;
          end else begin
            done_d    = 1'b1;
            ready_d   = 1'b1;
            timeout_d = !rs_q && bw_q && bf_q;
            state_d   = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      poll_q    <= '0;
      rs_q      <= 1'b0;
      bw_q      <= 1'b0;
      en_q      <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      rd_data_q <= '0;
      bf_q      <= 1'b0;
      ac_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      poll_q    <= poll_d;
      rs_q      <= rs_d;
      bw_q      <= bw_d;
      en_q      <= en_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      rd_data_q <= rd_data_d;
      bf_q      <= bf_d;
      ac_q      <= ac_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.busy_flag = bf_q;
  assign bus.addr_cnt  = ac_q;
  assign bus.lcd_rw    = 1'b1;
  assign bus.lcd_rs    = rs_q;
  assign bus.lcd_en    = en_q;

endmodule

// File: doc/lcd_reader.md
Name: lcd_reader

Overview:
- Read-side controller for the HD44780-compatible character LCD: runs timed read cycles (lcd_rw=1) on the LCD bus and returns either the busy-flag/address-counter byte (RS=0) or a DDRAM/CGRAM data byte (RS=1).
- Sits beside the LCD write path. The CPU or write sequencer calls it to poll the busy flag before each write, and to read back display contents.
- The LCD data bus arrives as a separate input. This block never drives the data bus.

Parameters:
- SETUP_CYC, 2: clocks RS/RW are held stable with EN low before EN rises (tAS). Must be >=1.
- EN_HIGH_CYC, 25: clocks EN is held high (25 clocks = 500 ns at 50 MHz). Must be >=2.
- HOLD_CYC, 2: clocks EN is held low after it falls, before the next cycle or completion (tAH/tH). Must be >=1.
- MAX_POLLS, 1000: maximum busy-flag reads in one busy_wait request before timeout. Must be >=1.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- req, input, 1: start request. Accepted only when ready=1.
- req_rs, input, 1: 0 = busy-flag/address read, 1 = data read. Latched on accept.
- busy_wait, input, 1: with req_rs=0, repeat reads until BF=0 or timeout. Ignored when req_rs=1. Latched on accept.
- ready, output, 1: high in IDLE.
- done, output, 1: one-cycle completion pulse.
- timeout, output, 1: valid with done. 1 = poll limit reached with BF still 1.
- rd_data, output, 8: last captured LCD byte. Held until the next capture.
- busy_flag, output, 1: rd_data[7] from the last RS=0 read.
- addr_cnt, output, 7: rd_data[6:0] from the last RS=0 read.
- lcd_rw, output, 1: LCD R/W.
- lcd_rs, output, 1: LCD RS.
- lcd_en, output, 1: LCD enable.
- lcd_data_in, input, 8: LCD data bus D7..D0.

Behaviour:
- Reset (async, immediate, including mid-cycle):
  - lcd_en=0, lcd_rw=1, lcd_rs=0.
  - ready=1, done=0, timeout=0.
  - rd_data=0, busy_flag=0, addr_cnt=0.
  - State goes to IDLE; poll count cleared.
  - Reset mid-operation never produces a done pulse.
- All outputs are registered. lcd_rw stays 1 at all times, since this block only reads.
- States:
  - IDLE -> SETUP -> EN_HIGH -> HOLD -> (SETUP | IDLE).
  - A cycle counter is loaded on each state entry.
- IDLE:
  - ready=1, lcd_en=0.
  - On a clock edge with req=1: latch req_rs and busy_wait, drive lcd_rs=req_rs, clear the poll count, go to SETUP, ready=0.
- SETUP: SETUP_CYC clocks, lcd_en=0, lcd_rs stable.
- EN_HIGH:
  - EN_HIGH_CYC clocks, lcd_en=1.
  - lcd_data_in is captured into rd_data on the last EN_HIGH clock edge, before EN falls.
  - If RS=0, busy_flag and addr_cnt update from the same capture.
- HOLD: HOLD_CYC clocks, lcd_en=0, lcd_rs unchanged. On the final HOLD edge:
  - If RS=0, busy_wait=1, captured BF=1, and fewer than MAX_POLLS reads have been done: go to SETUP for another read.
  - Otherwise: go to IDLE with done=1 for one cycle and ready=1 in the same cycle.
  - timeout=1 only when the exit is caused by reaching MAX_POLLS with BF=1. timeout clears on the next accept.
- Single-read latency: req accepted at edge N -> done high from edge N+SETUP_CYC+EN_HIGH_CYC+HOLD_CYC for exactly one cycle.
  - With defaults this is edge N+29.
  - lcd_en is high from edge N+SETUP_CYC to edge N+SETUP_CYC+EN_HIGH_CYC.
- Poll latency: each additional poll adds SETUP_CYC+EN_HIGH_CYC+HOLD_CYC clocks.
- req while ready=0 is ignored, not queued. req held high across done starts a new request at the edge after done.
- Changes on req_rs or busy_wait after accept have no effect.
- lcd_rs changes only in IDLE on accept. It never changes while lcd_en=1 or during HOLD.

Test Plan:
- Reset check: reset asserted mid-EN_HIGH -> lcd_en=0 immediately, lcd_rw=1, ready=1, rd_data=0x00, no done pulse.
- Single data read, defaults: req at edge N with req_rs=1 and lcd_data_in=0x41 -> lcd_rs=1, lcd_rw=1, lcd_en high exactly 25 clocks starting edge N+2, done at edge N+29, rd_data=0x41, busy_flag and addr_cnt unchanged.
- Busy read without wait: req_rs=0, busy_wait=0, lcd_data_in=0x8A -> one read only, rd_data=0x8A, busy_flag=1, addr_cnt=0x0A, timeout=0, done at N+29.
- Busy wait succeeds: req_rs=0, busy_wait=1, lcd_data_in=0x85 for the first two reads, then 0x05 -> three EN pulses, done at N+87, busy_flag=0, addr_cnt=0x05, timeout=0.
- Busy timeout: MAX_POLLS=4, lcd_data_in held at 0x80 -> exactly 4 EN pulses, done with timeout=1 and busy_flag=1. The next accept clears timeout.
- Request handling: req pulsed during EN_HIGH is ignored. req held high continuously -> back-to-back requests, each accepted on the edge after done. lcd_rs never toggles while lcd_en=1.
